// File: rtl/data_sync_pkg.sv
// Shared types and sizing helpers for the data-synchronizer transmit arbiter.
package data_sync_pkg;

    // Transmit controller states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Default number of CLK cycles allowed per handshake phase.
    localparam int DEFAULT_TIMEOUT = 255;

    // Width of a requester index; at least one bit even for two requesters.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the phase counter; it only has to reach timeout-1.
    function automatic int cnt_width(input int t);
        return (t <= 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/data_sync_tx_arbiter_ack_bit_sync.sv
// Multi-flop synchronizer bringing the destination acknowledge into CLK.
module ack_bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] stages;

    // Shift the asynchronous level through the flop chain, cleared on reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stages <= '0;
        end else begin
            stages <= {stages[NUM_STAGES-2:0], d};
        end
    end

    assign q = stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx_arbiter.sv
// Source-domain controller sharing one data-synchronizer channel among
// several requesters: round-robin arbitration, word capture, level enable
// and a 4-phase handshake against a synchronized destination acknowledge.
//
// Handshake: requester i holds req[i] high until it sees req_gnt[i]; the
// word is captured at the grant edge.  bus_enable rises one cycle after
// capture, stays high until the synchronized ack is seen (or the phase
// times out), and the channel is released once the ack has dropped again.
module data_sync_tx_arbiter
    import data_sync_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [DATA_WIDTH-1:0]           unsync_bus,
    output logic [id_width(NUM_REQ)-1:0]    tx_id,
    output logic                            bus_enable,
    input  logic                            dst_ack,
    output logic                            busy
);

    localparam int IW = id_width(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    state_t                 state;
    logic [IW-1:0]          last;
    logic [CW-1:0]          cnt;
    logic                   err_flag;
    logic                   ack_s;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [DATA_WIDTH-1:0]  pick_word;
    logic                   phase_expired;

    // Round-robin search: first set request after 'prev', wrapping around.
    // Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      prev);
        logic          found;
        logic [IW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(prev) + i) % NUM_REQ;
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        return {found, idx};
    endfunction

    // One-hot pulse vector for a requester index.
    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IW-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

    ack_bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (dst_ack),
        .q   (ack_s)
    );

    // Arbitration result and the winner's word, evaluated every cycle.
    always_comb begin
        {pick_valid, pick_idx} = rr_pick(req, last);
        pick_word = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Current handshake phase has used up its cycle allowance.
    assign phase_expired = TO_EN && (cnt == CNT_LAST);

    // Transmit FSM with registered bus, id, enable and pulse outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last       <= LAST_INIT;
            cnt        <= '0;
            err_flag   <= 1'b0;
            unsync_bus <= '0;
            tx_id      <= '0;
            bus_enable <= 1'b0;
            req_gnt    <= '0;
            req_done   <= '0;
            req_err    <= '0;
        end else begin
            req_gnt  <= '0;
            req_done <= '0;
            req_err  <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        req_gnt    <= id_onehot(pick_idx);
                        unsync_bus <= pick_word;
                        tx_id      <= pick_idx;
                        last       <= pick_idx;
                        state      <= SETUP;
                    end
                end
                // Data has been stable for one cycle before the enable edge.
                SETUP: begin
                    bus_enable <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        bus_enable <= 1'b0;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end else if (phase_expired) begin
                        bus_enable <= 1'b0;
                        err_flag   <= 1'b1;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        if (err_flag) begin
                            req_err <= id_onehot(tx_id);
                        end else begin
                            req_done <= id_onehot(tx_id);
                        end
                        err_flag <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else if (phase_expired) begin
                        // Acknowledge stuck high: give the channel back anyway.
                        req_err  <= id_onehot(tx_id);
                        err_flag <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Directed bench for data_sync_tx_arbiter with a small destination model.
`timescale 1ns/1ps
module tb_data_sync_tx_arbiter;

    logic        CLK;
    logic        RST;
    logic        dst_clk;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_gnt;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic [7:0]  unsync_bus;
    logic [1:0]  tx_id;
    logic        bus_enable;
    logic        dst_ack;
    logic        busy;

    // destination model
    logic        auto_ack;
    logic        ack_man;
    logic        ack_auto;
    logic        en_s1, en_s2, en_s3;
    logic [7:0]  sync_bus;

    int checks = 0;
    int errors = 0;

    assign dst_ack = auto_ack ? ack_auto : ack_man;

    data_sync_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_WIDTH  (8),
        .NUM_STAGES  (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .req_gnt    (req_gnt),
        .req_done   (req_done),
        .req_err    (req_err),
        .unsync_bus (unsync_bus),
        .tx_id      (tx_id),
        .bus_enable (bus_enable),
        .dst_ack    (dst_ack),
        .busy       (busy)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        dst_clk = 1'b0;
        #1;
        forever #3 dst_clk = ~dst_clk;
    end

    // Destination side: synchronize the enable, capture the bus on its
    // synchronized rising edge and return the enable level as the ack.
    always @(posedge dst_clk or negedge RST) begin
        if (!RST) begin
            en_s1    <= 1'b0;
            en_s2    <= 1'b0;
            en_s3    <= 1'b0;
            ack_auto <= 1'b0;
            sync_bus <= '0;
        end else begin
            en_s1 <= bus_enable;
            en_s2 <= en_s1;
            en_s3 <= en_s2;
            if (en_s2 && !en_s3) sync_bus <= unsync_bus;
            ack_auto <= en_s2;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        int n;
        n = 0;
        while (req_gnt == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        g = req_gnt;
    endtask

    task automatic wait_end(output logic [3:0] d, output logic [3:0] e);
        int n;
        n = 0;
        while ((req_done | req_err) == 4'b0 && n < 60) begin
            tick();
            n++;
        end
        d = req_done;
        e = req_err;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
    endtask

    logic [7:0] words [4];
    logic [3:0] g, d, e;
    int         hi_cnt;
    int         n;

    initial begin
        words[0] = 8'h10;
        words[1] = 8'h21;
        words[2] = 8'h32;
        words[3] = 8'h43;
        RST      = 1'b0;
        req      = '0;
        req_data = '0;
        auto_ack = 1'b0;
        ack_man  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_bus_enable", bus_enable, 0);
        check("rst_unsync_bus", unsync_bus, 0);
        check("rst_tx_id", tx_id, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {req_gnt, req_done, req_err}, 0);
        RST = 1'b1;
        tick();

        // ---- single transfer, manual ack ----
        req      = 4'b0010;
        req_data = {8'h77, 8'h66, 8'hA5, 8'h55};
        tick();                                   // edge 1: grant
        check("single_gnt", req_gnt, 4'b0010);
        check("single_tx_id", tx_id, 1);
        check("single_bus", unsync_bus, 8'hA5);
        check("single_en_edge1", bus_enable, 0);
        check("single_busy", busy, 1);
        req = '0;
        tick();                                   // edge 2: enable
        check("single_en_edge2", bus_enable, 1);
        check("single_gnt_pulse", req_gnt, 0);
        tick();
        tick();
        tick();
        ack_man = 1'b1;
        // two synchronizer flops plus the registered FSM edge
        tick();
        check("single_en_ack1", bus_enable, 1);
        tick();
        check("single_en_ack2", bus_enable, 1);
        tick();
        check("single_en_ack3", bus_enable, 0);
        check("single_bus_hold", unsync_bus, 8'hA5);
        ack_man = 1'b0;
        tick();
        check("single_done_early1", req_done, 0);
        tick();
        check("single_done_early2", req_done, 0);
        tick();
        check("single_done", req_done, 4'b0010);
        check("single_err", req_err, 0);
        check("single_idle", busy, 0);
        tick();

        // ---- round-robin, all requesting, auto ack ----
        apply_reset();
        auto_ack = 1'b1;
        req      = 4'b1111;
        req_data = {words[3], words[2], words[1], words[0]};
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            check("rr_gnt", g, 32'(1) << (i % 4));
            check("rr_word", unsync_bus, words[i % 4]);
            check("rr_tx_id", tx_id, i % 4);
            if (i == 4) req = '0;
            wait_end(d, e);
            check("rr_done", d, 32'(1) << (i % 4));
            check("rr_no_err", e, 0);
            check("rr_sync_bus", sync_bus, words[i % 4]);
        end
        tick();
        tick();
        check("rr_idle", busy, 0);

        // ---- data stability while enable is high ----
        req      = 4'b0100;
        req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
        wait_gnt(g);
        check("stab_gnt", g, 4'b0100);
        check("stab_capture", unsync_bus, 8'h5C);
        req    = '0;
        hi_cnt = 0;
        n      = 0;
        while ((req_done | req_err) == 4'b0 && n < 60) begin
            req_data = $urandom;
            tick();
            n++;
            if (bus_enable) begin
                hi_cnt++;
                check("stab_bus", unsync_bus, 8'h5C);
            end
        end
        check("stab_done", req_done, 4'b0100);
        check("stab_enable_seen", hi_cnt > 0, 1);
        check("stab_sync_bus", sync_bus, 8'h5C);
        auto_ack = 1'b0;
        tick();

        // ---- WAIT_ACK timeout, no ack ----
        req = 4'b1000;
        wait_gnt(g);
        check("to_gnt", g, 4'b1000);
        req = '0;
        tick();
        hi_cnt = 0;
        while (bus_enable && hi_cnt < 20) begin
            hi_cnt++;
            tick();
        end
        check("to_enable_cycles", hi_cnt, 8);
        tick();
        check("to_err", req_err, 4'b1000);
        check("to_done", req_done, 0);
        check("to_idle", busy, 0);
        tick();

        // ---- RELEASE timeout with ack stuck high ----
        req = 4'b0001;
        wait_gnt(g);
        check("stuck_gnt", g, 4'b0001);
        req = '0;
        tick();
        ack_man = 1'b1;
        n = 0;
        while (bus_enable && n < 20) begin
            tick();
            n++;
        end
        check("stuck_en_low", bus_enable, 0);
        n = 0;
        while (req_err == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check("stuck_release_cycles", n, 8);
        check("stuck_err", req_err, 4'b0001);
        check("stuck_done", req_done, 0);
        check("stuck_idle", busy, 0);
        ack_man = 1'b0;
        tick();
        tick();
        tick();

        // ---- reset in the middle of WAIT_ACK ----
        req = 4'b0001;
        wait_gnt(g);
        check("mid_gnt", g, 4'b0001);
        req = '0;
        tick();
        tick();
        check("mid_pre_enable", bus_enable, 1);
        #2;
        RST = 1'b0;
        #1;
        check("mid_enable", bus_enable, 0);
        check("mid_busy", busy, 0);
        check("mid_bus", unsync_bus, 0);
        check("mid_tx_id", tx_id, 0);
        check("mid_pulses", {req_gnt, req_done, req_err}, 0);
        tick();
        tick();
        check("mid_no_pulse", {req_done, req_err}, 0);
        RST = 1'b1;
        tick();
        // last grant was requester 0; only a reset pointer picks 0 over 1 here
        req = 4'b0011;
        wait_gnt(g);
        check("mid_ptr_gnt", g, 4'b0001);
        req = '0;
        wait_end(d, e);
        check("mid_after_err", e, 4'b0001);
        check("mid_after_done", d, 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
